// File: rtl/vector_sequencer.sv
// vector_sequencer: applies stored test vectors to a CPU under test, waits a
// settle time, compares the CPU display output against the expected word and
// accumulates pass/mismatch statistics.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for start; results of the previous run are held
//   ST_FETCH  | vec_addr presents the current index to the vector memory
//   ST_LOAD   | memory word arrives; apply gpio_in/dut_rst, arm settle timer
//   ST_SETTLE | settle timer counts down to zero
//   ST_CHECK  | compare gpio_out with expected, advance index or finish
//   ST_DONE   | run finished; done=1, results and applied stimulus held
module vector_sequencer #(
  parameter int NVEC   = 150,
  parameter int SETTLE = 6
) (
  input  logic        clk2,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  vec_addr,
  input  logic [67:0] vec_data,
  output logic        dut_rst,
  output logic [31:0] gpio_in,
  input  logic [31:0] gpio_out,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [15:0] err_count,
  output logic [15:0] pass_count,
  output logic [7:0]  first_fail
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LOAD, ST_SETTLE, ST_CHECK, ST_DONE
  } state_t;

  localparam logic [7:0] LP_LAST   = 8'(NVEC - 1);
  localparam logic [7:0] LP_SETTLE = 8'(SETTLE);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_index;
  logic [7:0]  r_settle_cnt;
  logic [31:0] r_expected;
  logic [31:0] r_gpio_in;
  logic        r_dut_rst;
  logic        r_fail;
  logic [15:0] r_err_count;
  logic [15:0] r_pass_count;
  logic [7:0]  r_first_fail;
  logic        w_busy;
  logic        w_abort;
  logic        w_last;

  assign w_last  = (r_index == LP_LAST);
  assign w_abort = w_busy && abort;

  // State register
  always_ff @(posedge clk2) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and status decode; abort wins over every other transition
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_FETCH;
      ST_FETCH:  begin w_busy = 1'b1; w_next = ST_LOAD; end
      ST_LOAD:   begin w_busy = 1'b1; w_next = ST_SETTLE; end
      ST_SETTLE: begin
        w_busy = 1'b1;
        if (r_settle_cnt <= 8'd1) w_next = ST_CHECK;
      end
      ST_CHECK:  begin
        w_busy = 1'b1;
        w_next = w_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE:   begin
        done = 1'b1;
        if (start) w_next = ST_FETCH;
      end
      default:   w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // Datapath: stimulus application, settle timer, result accumulation
  always_ff @(posedge clk2) begin
    if (!rst) begin
      r_index      <= 8'd0;
      r_settle_cnt <= 8'd0;
      r_expected   <= 32'd0;
      r_gpio_in    <= 32'd0;
      r_dut_rst    <= 1'b1;
      r_fail       <= 1'b0;
      r_err_count  <= 16'd0;
      r_pass_count <= 16'd0;
      r_first_fail <= 8'd0;
    end else if (w_abort) begin
      // Park the CPU in reset; statistics stay readable
      r_dut_rst <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_index      <= 8'd0;
            r_fail       <= 1'b0;
            r_err_count  <= 16'd0;
            r_pass_count <= 16'd0;
            r_first_fail <= 8'd0;
          end
        end
        ST_LOAD: begin
          r_gpio_in    <= vec_data[63:32];
          r_expected   <= vec_data[31:0];
          r_dut_rst    <= |vec_data[67:64];
          r_settle_cnt <= LP_SETTLE;
        end
        ST_SETTLE: begin
          r_settle_cnt <= r_settle_cnt - 8'd1;
        end
        ST_CHECK: begin
          // Vectors that hold the CPU in reset are not scored
          if (!r_dut_rst) begin
            if (gpio_out != r_expected) begin
              if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
              if (!r_fail) r_first_fail <= r_index;
              r_fail <= 1'b1;
            end else if (r_pass_count != 16'hFFFF) begin
              r_pass_count <= r_pass_count + 16'd1;
            end
          end
          if (!w_last) r_index <= r_index + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign vec_addr   = r_index;
  assign dut_rst    = r_dut_rst;
  assign gpio_in    = r_gpio_in;
  assign busy       = w_busy;
  assign fail       = r_fail;
  assign err_count  = r_err_count;
  assign pass_count = r_pass_count;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_vector_sequencer.sv
// Testbench for vector_sequencer with NVEC=4, SETTLE=6. The CPU under test is
// modelled as echoing gpio_in onto gpio_out; the vector memory has one cycle
// of read latency. Expected run results come from a per-vector scoring model.
module tb_vector_sequencer;

  localparam int NV  = 4;
  localparam int ST  = 6;
  localparam int LAT = NV * (3 + ST);

  logic        clk2 = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  vec_addr;
  logic [67:0] vec_data;
  logic        dut_rst;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        busy;
  logic        done;
  logic        fail;
  logic [15:0] err_count;
  logic [15:0] pass_count;
  logic [7:0]  first_fail;

  logic [67:0] mem [NV];
  int checks   = 0;
  int failures = 0;

  vector_sequencer #(.NVEC(NV), .SETTLE(ST)) u_dut (
    .clk2(clk2), .rst(rst), .start(start), .abort(abort),
    .vec_addr(vec_addr), .vec_data(vec_data), .dut_rst(dut_rst),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .busy(busy), .done(done),
    .fail(fail), .err_count(err_count), .pass_count(pass_count),
    .first_fail(first_fail)
  );

  always #5 clk2 = ~clk2;

  // Vector memory: registered read, data valid one cycle after the address
  always @(posedge clk2) vec_data <= mem[vec_addr[1:0]];

  // CPU model: display output mirrors the switch input
  assign gpio_out = gpio_in;

  task automatic step();
    @(posedge clk2);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Score a whole run from the vector table
  task automatic predict(output int p, output int e, output int ff,
                         output logic [31:0] lg, output logic lr);
    p = 0; e = 0; ff = -1;
    for (int i = 0; i < NV; i++) begin
      logic [67:0] w;
      w = mem[i];
      if (w[67:64] == 4'h0) begin
        if (w[63:32] == w[31:0]) p++;
        else begin
          e++;
          if (ff < 0) ff = i;
        end
      end
    end
    if (ff < 0) ff = 0;
    w_last_fill(lg, lr);
  endtask

  task automatic w_last_fill(output logic [31:0] lg, output logic lr);
    logic [67:0] w;
    w = mem[NV-1];
    lg = w[63:32];
    lr = (w[67:64] != 4'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, 32'(vec_addr), 32'd0);
    check({tag, "_dutrst"}, 32'(dut_rst), 32'd1);
    check({tag, "_gpio"}, gpio_in, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fail"}, 32'(fail), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_pass"}, 32'(pass_count), 32'd0);
    check({tag, "_ff"}, 32'(first_fail), 32'd0);
  endtask

  // Full run from start to DONE with exact latency check; optional stray
  // start pulses while the run is in progress
  task automatic run_check(input string tag, input bit spurious);
    int p, e, ff;
    logic [31:0] lg;
    logic lr;
    predict(p, e, ff, lg, lr);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    check({tag, "_addr0"}, 32'(vec_addr), 32'd0);
    for (int i = 0; i < LAT - 1; i++) begin
      start = spurious && (i % 7 == 3);
      step();
    end
    start = 1'b0;
    check({tag, "_done_early"}, 32'(done), 32'd0);
    step();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pass"}, 32'(pass_count), 32'(p));
    check({tag, "_err"}, 32'(err_count), 32'(e));
    check({tag, "_fail"}, 32'(fail), 32'(e != 0));
    check({tag, "_ff"}, 32'(first_fail), 32'(ff));
    check({tag, "_gpio"}, gpio_in, lg);
    check({tag, "_dutrst"}, 32'(dut_rst), 32'(lr));
    check({tag, "_addr"}, 32'(vec_addr), 32'(NV - 1));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    mem[0] = {4'h1, 32'h0000_0000, 32'hDEAD_BEEF};
    for (int i = 1; i < NV; i++) mem[i] = {4'h0, 32'h0000_0005, 32'h0000_0005};

    // Reset held three cycles, then released
    repeat (3) step();
    rst = 1'b1;
    check_reset_values("rst");
    repeat (5) step();
    check("rst_idle_busy", 32'(busy), 32'd0);
    check("rst_idle_done", 32'(done), 32'd0);

    // Full pass: vector 0 holds the CPU in reset, three matching vectors
    run_check("fullpass", 1'b0);

    // Mismatch on vector 2, started from DONE
    mem[2] = {4'h0, 32'h0000_0009, 32'h0000_000A};
    run_check("mismatch", 1'b0);

    // Restart after a failing run clears the results
    mem[2] = {4'h0, 32'h0000_0005, 32'h0000_0005};
    run_check("restart", 1'b0);

    // Abort in DONE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_done_done", 32'(done), 32'd1);
    check("abort_done_dutrst", 32'(dut_rst), 32'd0);
    check("abort_done_pass", 32'(pass_count), 32'd3);

    // Abort during settle of vector 1
    mem[0] = {4'h0, 32'h0000_0011, 32'h0000_0011};
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    check("abort_pre_dutrst", 32'(dut_rst), 32'd0);
    check("abort_pre_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dutrst", 32'(dut_rst), 32'd1);
    check("abort_pass", 32'(pass_count), 32'd1);
    check("abort_err", 32'(err_count), 32'd0);
    check("abort_addr", 32'(vec_addr), 32'd1);
    repeat (3) step();
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_frozen_pass", 32'(pass_count), 32'd1);

    // Stray start pulses during a run change nothing
    run_check("busystart", 1'b1);

    // Start and abort together while busy: abort wins
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("startabort_busy", 32'(busy), 32'd0);
    check("startabort_done", 32'(done), 32'd0);
    check("startabort_pass", 32'(pass_count), 32'd0);
    repeat (2) step();
    check("startabort_idle", 32'(busy), 32'd0);

    // Randomized vector tables
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NV; i++) begin
        logic [31:0] g;
        logic [3:0]  n;
        g = $urandom;
        n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        mem[i] = {n, g, ($urandom_range(0, 1) == 1) ? g : 32'($urandom)};
      end
      run_check($sformatf("rand%0d", r), r[0]);
    end

    // Reset in the middle of a failing run
    mem[0] = {4'h0, 32'h0000_0001, 32'h0000_0002};
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (14) step();
    check("midrst_pre_fail", 32'(fail), 32'd1);
    check("midrst_pre_err", 32'(err_count), 32'd1);
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    check_reset_values("midrst");
    repeat (4) step();
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_idle_addr", 32'(vec_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
